cplx_delay_line: RTL and testbench

- Parametrised, valid-gated delay buffer for complex samples (separate real and imaginary words).
- Replaces fixed-length shift-register buffers in the radix-3 SDF FFT datapath with one block; the length is selected at run time (1, 3, 9, 27, … samples, or any value up to `DEPTH_MAX`).
- Advances only on valid input, so pipeline stalls do not corrupt alignment.
- Supports flush, re-priming on depth change, and a zero-delay register bypass.

---
 rtl/cplx_dly_pkg.sv | 16 +
 rtl/cplx_dly_ram.sv | 26 ++
 rtl/cplx_delay_line.sv | 95 +++++++++
 tb/tb_cplx_delay_line.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cplx_dly_pkg.sv
// cplx_dly_pkg: shared defaults, depth clamp helper and complex sample type for cplx_delay_line
package cplx_dly_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int DEPTH_MAX_DEF = 27;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] re;
        logic [WIDTH_DEF-1:0] img;
    } cplx_t;

    function automatic int unsigned clamp_depth(input int unsigned sel, input int unsigned dmax);
        return (sel > dmax) ? dmax : sel;
    endfunction

endpackage

// File: rtl/cplx_dly_ram.sv
// cplx_dly_ram: DEPTH x 2*WIDTH sample store, single address, read-before-write
//   clk   - write clock
//   we    - write enable
//   addr  - shared read/write address
//   wdata - {re, img} written on the rising edge when we=1
//   rdata - contents at addr before this cycle's write lands
module cplx_dly_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 27,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [2*WIDTH-1:0] wdata,
    output logic [2*WIDTH-1:0] rdata
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

endmodule

// File: rtl/cplx_delay_line.sv
// cplx_delay_line: valid-gated, run-time-length delay line for complex samples
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   flush     - synchronous clear of pointer/fill state (sample that cycle dropped)
//   depth_sel - requested delay in valid samples, clamped to DEPTH_MAX (0 = register bypass)
//   in_valid  - in_re/in_img carry a sample
//   in_re     - real part in
//   in_img    - imaginary part in
//   out_valid - out_re/out_img carry a delayed sample
//   out_re    - delayed real part
//   out_img   - delayed imaginary part
//   primed    - buffer holds depth valid samples (always 1 in bypass)
// Build option: define CPLX_DLY_ZERO_FILL_EN to force outputs to 0 while filling.
module cplx_delay_line
    import cplx_dly_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH_MAX = DEPTH_MAX_DEF,
    parameter int DW        = $clog2(DEPTH_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [DW-1:0]    depth_sel,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_img,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_img,
    output logic             primed
);

    localparam int AW = $clog2(DEPTH_MAX);

    logic [DW-1:0]      d_q, d_new, ptr, fill;
    logic               chg, full, adv, bypass;
    logic [2*WIDTH-1:0] rd_data, fill_data;

    assign d_new  = DW'(clamp_depth(32'(depth_sel), 32'(DEPTH_MAX)));
    assign chg    = d_new != d_q;
    // fill never exceeds d_q, so full also covers the bypass case (d_q = fill = 0)
    assign full   = fill == d_q;
    assign bypass = d_q == '0;
    assign adv    = in_valid && !flush && !chg && !bypass;

    cplx_dly_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH_MAX), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (adv),
        .addr  (ptr[AW-1:0]),
        .wdata ({in_re, in_img}),
        .rdata (rd_data)
    );

`ifdef CPLX_DLY_ZERO_FILL_EN
    assign fill_data = full ? rd_data : '0;
`else
    assign fill_data = rd_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q       <= d_new;
            ptr       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_img   <= '0;
            primed    <= d_new == '0;
        end else if (flush) begin
            ptr       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            primed    <= bypass;
        end else if (chg) begin
            d_q       <= d_new;
            ptr       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            primed    <= d_new == '0;
        end else begin
            primed    <= full;
            out_valid <= in_valid && full;
            if (in_valid) begin
                out_re  <= bypass ? in_re  : fill_data[2*WIDTH-1:WIDTH];
                out_img <= bypass ? in_img : fill_data[WIDTH-1:0];
            end
            if (adv) begin
                ptr  <= (ptr == d_q - 1'b1) ? '0 : ptr + 1'b1;
                fill <= full ? fill : fill + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cplx_delay_line.sv
// tb_cplx_delay_line: randomized and directed checks of cplx_delay_line against a FIFO-queue reference
module tb_cplx_delay_line;
    import cplx_dly_pkg::*;

    localparam int WIDTH = 32;
    localparam int DMAX  = 27;
    localparam int DW    = $clog2(DMAX + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [DW-1:0]    depth_sel;
    logic             in_valid;
    logic [WIDTH-1:0] in_re, in_img;
    logic             out_valid;
    logic [WIDTH-1:0] out_re, out_img;
    logic             primed;

    cplx_delay_line #(.WIDTH(WIDTH), .DEPTH_MAX(DMAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .depth_sel (depth_sel),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_img    (in_img),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_img   (out_img),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    cplx_t q[$];
    int    dm;
    bit    exp_v, exp_p, known;
    cplx_t exp_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit f, input int sel, input bit v, input logic [31:0] re, input logic [31:0] im);
        int    dn;
        cplx_t s;
        flush     = f;
        depth_sel = DW'(sel);
        in_valid  = v;
        in_re     = re;
        in_img    = im;
        s.re      = re;
        s.img     = im;
        dn        = (sel > DMAX) ? DMAX : sel;
        @(posedge clk);
        if (f) begin
            q.delete();
            exp_v = 0;
            exp_p = (dm == 0);
        end else if (dn != dm) begin
            dm = dn;
            q.delete();
            exp_v = 0;
            exp_p = (dm == 0);
        end else begin
            exp_p = (q.size() == dm);
            exp_v = 0;
            if (v) begin
                if (dm == 0) begin
                    exp_v = 1;
                    exp_d = s;
                    known = 1;
                end else if (q.size() == dm) begin
                    exp_v = 1;
                    exp_d = q.pop_front();
                    known = 1;
                    q.push_back(s);
                end else begin
`ifdef CPLX_DLY_ZERO_FILL_EN
                    exp_d = '0;
                    known = 1;
`else
                    known = 0;
`endif
                    q.push_back(s);
                end
            end
        end
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        chk("primed", 64'(primed), 64'(exp_p));
        if (known) chk("data", {out_re, out_img}, exp_d);
    endtask

    task automatic do_reset(input int sel);
        #2;
        depth_sel = DW'(sel);
        flush     = 0;
        in_valid  = 0;
        rst_n     = 0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", {out_re, out_img}, 64'd0);
        chk("rst_primed", 64'(primed), 64'(sel == 0));
        @(negedge clk);
        rst_n = 1;
        q.delete();
        dm    = (sel > DMAX) ? DMAX : sel;
        exp_v = 0;
        exp_p = (dm == 0);
        exp_d = '0;
        known = 1;
    endtask

    int choices[7] = '{0, 1, 2, 3, 9, 27, 31};

    initial begin
        rst_n = 1; flush = 0; depth_sel = '0; in_valid = 0; in_re = '0; in_img = '0;
        dm = 0; exp_v = 0; exp_p = 0; known = 0; exp_d = '0;
        @(negedge clk);
        do_reset(9);
        for (int n = 1; n <= 40; n++) cycle(0, 9, 1, 32'(n), 32'(-n));
        for (int n = 0; n < 40; n++) cycle(0, 27, 1, $urandom, $urandom);
        for (int n = 1; n <= 24; n++) cycle(0, 3, (n % 2) == 1, 32'(n), ~32'(n));
        for (int n = 0; n < 30; n++) cycle(0, 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
        for (int n = 0; n < 30; n++) cycle(0, 27, 1, $urandom, $urandom);
        cycle(1, 27, 1, 32'hDEAD_BEEF, 32'hFEED_F00D);
        for (int n = 0; n < 30; n++) cycle(0, 27, 1, $urandom, $urandom);
        for (int n = 0; n < 10; n++) cycle(0, 31, 1, $urandom, $urandom);
        cycle(1, 31, 1, 32'hBAD0_0001, 32'hBAD0_0002);
        for (int n = 0; n < 30; n++) cycle(0, 31, 1, $urandom, $urandom);
        for (int s = 0; s < 8; s++) begin
            int sel;
            sel = choices[$urandom_range(0, 6)];
            for (int n = 0; n < 40; n++)
                cycle($urandom_range(0, 19) == 0, sel, $urandom_range(0, 3) != 0, $urandom, $urandom);
        end
        for (int n = 0; n < 10; n++) cycle(0, 3, 1, $urandom, $urandom);
        do_reset(3);
        for (int n = 0; n < 10; n++) cycle(0, 3, 1, $urandom, $urandom);
        do_reset(0);
        for (int n = 0; n < 6; n++) cycle(0, 0, 1, $urandom, $urandom);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
